// File: rtl/seq_addsub_pkg.sv
// Shared types and helpers for the sequential slice-wise add/subtract unit.
package seq_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Slice counter width; a single-slice configuration still needs one bit.
   function automatic int cnt_w(input int width, input int chunk);
      int n;
      n = width / chunk;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_addsub_chunk.sv
// Combinational CHUNK-bit add/subtract slice; subtract is A + ~B + carry.
module addsub_chunk
   import seq_addsub_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             mode,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             a_msb,
   output logic             bop_msb,
   output logic             s_msb
);

   logic [CHUNK-1:0] bop;
   logic [CHUNK:0]   sum;

   assign bop     = (mode == MODE_SUB) ? ~b : b;
   assign sum     = {1'b0, a} + {1'b0, bop} + {{CHUNK{1'b0}}, cin};
   assign s       = sum[CHUNK-1:0];
   assign cout    = sum[CHUNK];
   assign a_msb   = a[CHUNK-1];
   assign bop_msb = bop[CHUNK-1];
   assign s_msb   = sum[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK slice per cycle, LSB slice first.
// Optional signed saturation on overflow: define SEQ_ADDSUB_SAT_EN.
module seq_addsub
   import seq_addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic             MODE,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] RESULT,
   output logic             COUT,
   output logic             ZERO,
   output logic             NEG,
   output logic             OVF
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int CW     = cnt_w(WIDTH, CHUNK);

   if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_err
      $error("seq_addsub: WIDTH must be a positive multiple of CHUNK");
   end

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r, b_r, res_r;
   logic             mode_r, c_r;
   logic             in_ready_r, out_valid_r;
   logic             cout_r, zero_r, neg_r, ovf_r;

   logic [31:0]      base;
   logic [CHUNK-1:0] s;
   logic             c_out, a_msb, bop_msb, s_msb;
   logic             last, ovf_nxt;
   logic [WIDTH-1:0] res_nxt, fin;

   assign base = 32'(cnt) * CHUNK;
   assign last = (cnt == CW'(NCHUNK - 1));

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a       (a_r[base +: CHUNK]),
      .b       (b_r[base +: CHUNK]),
      .mode    (mode_r),
      .cin     (c_r),
      .s       (s),
      .cout    (c_out),
      .a_msb   (a_msb),
      .bop_msb (bop_msb),
      .s_msb   (s_msb)
   );

   always_comb begin
      res_nxt = res_r;
      res_nxt[base +: CHUNK] = s;
   end

   // Only meaningful on the last slice, where the slice MSBs are the word MSBs.
   assign ovf_nxt = (a_msb == bop_msb) && (s_msb != a_msb);

`ifdef SEQ_ADDSUB_SAT_EN
   function automatic logic signed [WIDTH-1:0] sat_clamp(input logic a_sign);
      logic signed [WIDTH-1:0] v;
      v = {WIDTH{~a_sign}};
      v[WIDTH-1] = a_sign;
      return v;
   endfunction

   assign fin = ovf_nxt ? sat_clamp(a_msb) : res_nxt;
`else
   assign fin = res_nxt;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         cnt         <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         res_r       <= '0;
         cout_r      <= 1'b0;
         zero_r      <= 1'b0;
         neg_r       <= 1'b0;
         ovf_r       <= 1'b0;
         a_r         <= '0;
         b_r         <= '0;
         mode_r      <= MODE_ADD;
         c_r         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (IN_VALID) begin
                  a_r        <= A;
                  b_r        <= B;
                  mode_r     <= MODE;
                  c_r        <= (MODE == MODE_SUB) ? ~CIN : CIN;
                  cnt        <= '0;
                  in_ready_r <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               c_r <= c_out;
               cnt <= cnt + 1'b1;
               if (last) begin
                  res_r       <= fin;
                  cout_r      <= (mode_r == MODE_SUB) ? ~c_out : c_out;
                  ovf_r       <= ovf_nxt;
                  zero_r      <= (fin == '0);
                  neg_r       <= fin[WIDTH-1];
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
                  res_r <= res_nxt;
               end
            end
            DONE: begin
               if (OUT_READY) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign IN_READY  = in_ready_r;
   assign OUT_VALID = out_valid_r;
   assign RESULT    = res_r;
   assign COUT      = cout_r;
   assign ZERO      = zero_r;
   assign NEG       = neg_r;
   assign OVF       = ovf_r;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed scoreboard bench for seq_addsub (WIDTH=32, CHUNK=8).
module tb_seq_addsub;

   typedef struct {
      logic [31:0] res;
      logic        cout;
      logic        zero;
      logic        neg;
      logic        ovf;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic        MODE = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        CIN = 1'b0;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b0;
   logic [31:0] RESULT;
   logic        COUT, ZERO, NEG, OVF;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   seq_addsub #(.WIDTH(32), .CHUNK(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .MODE      (MODE),
      .A         (A),
      .B         (B),
      .CIN       (CIN),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .RESULT    (RESULT),
      .COUT      (COUT),
      .ZERO      (ZERO),
      .NEG       (NEG),
      .OVF       (OVF)
   );

   always #5 CLK = ~CLK;

   // Whole-word reference: 33-bit arithmetic, borrow from the sign of the extended difference.
   function automatic exp_t model(input logic mode, input logic [31:0] a,
                                  input logic [31:0] b, input logic cin);
      exp_t        e;
      logic [32:0] full;
      if (mode) begin
         full  = {1'b0, a} - {1'b0, b} - {32'd0, cin};
         e.ovf = (a[31] != b[31]) && (full[31] != a[31]);
      end else begin
         full  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
         e.ovf = (a[31] == b[31]) && (full[31] != a[31]);
      end
      e.res  = full[31:0];
      e.cout = full[32];
`ifdef SEQ_ADDSUB_SAT_EN
      if (e.ovf) e.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      e.zero = (e.res == 32'd0);
      e.neg  = e.res[31];
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic launch_op(input logic mode, input logic [31:0] a,
                            input logic [31:0] b, input logic cin);
      int i;
      for (i = 0; i < 20 && !IN_READY; i++) begin
         @(posedge CLK); #1;
      end
      check("in_ready_before_launch", 32'(IN_READY), 32'd1);
      MODE = mode; A = a; B = b; CIN = cin; IN_VALID = 1'b1;
      sb.push_back(model(mode, a, b, cin));
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int lat;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         lat++;
         if (OUT_VALID) break;
      end
      check({tag, "_latency"}, 32'(lat), 32'd4);
   endtask

   task automatic compare_pop(input string tag);
      exp_t e;
      check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_result"}, RESULT, e.res);
         check({tag, "_cout"}, 32'(COUT), 32'(e.cout));
         check({tag, "_zero"}, 32'(ZERO), 32'(e.zero));
         check({tag, "_neg"}, 32'(NEG), 32'(e.neg));
         check({tag, "_ovf"}, 32'(OVF), 32'(e.ovf));
      end
   endtask

   task automatic release_out(input string tag);
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
      check({tag, "_out_valid_drop"}, 32'(OUT_VALID), 32'd0);
      check({tag, "_in_ready_back"}, 32'(IN_READY), 32'd1);
   endtask

   task automatic full_op(input string tag, input logic mode, input logic [31:0] a,
                          input logic [31:0] b, input logic cin);
      launch_op(mode, a, b, cin);
      wait_out(tag);
      compare_pop(tag);
      release_out(tag);
   endtask

   initial begin
      logic [31:0] held;

      // Reset state
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      check("rst_in_ready", 32'(IN_READY), 32'd1);
      check("rst_out_valid", 32'(OUT_VALID), 32'd0);
      check("rst_result", RESULT, 32'd0);
      check("rst_flags", {28'd0, COUT, ZERO, NEG, OVF}, 32'd0);

      // Directed arithmetic cases
      full_op("sub_5_3",      1'b1, 32'd5,          32'd3, 1'b0);
      full_op("sub_3_5",      1'b1, 32'd3,          32'd5, 1'b0);
      full_op("sub_5_5",      1'b1, 32'd5,          32'd5, 1'b0);
      full_op("add_ff_0_c1",  1'b0, 32'hFFFF_FFFF,  32'd0, 1'b1);
      full_op("add_pos_ovf",  1'b0, 32'h7FFF_FFFF,  32'd1, 1'b0);
      full_op("sub_neg_ovf",  1'b1, 32'h8000_0000,  32'd1, 1'b0);
      full_op("sub_0_0_b1",   1'b1, 32'd0,          32'd0, 1'b1);
      full_op("add_mixed",    1'b0, 32'h1234_5678,  32'h8765_4321, 1'b0);

      // Backpressure: DONE holds while new operands are offered
      launch_op(1'b0, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
      wait_out("bp");
      held = RESULT;
      MODE = 1'b1; A = 32'd100; B = 32'd1; CIN = 1'b0; IN_VALID = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         check("bp_hold_result", RESULT, held);
         check("bp_hold_valid", 32'(OUT_VALID), 32'd1);
         check("bp_hold_in_ready", 32'(IN_READY), 32'd0);
      end
      compare_pop("bp");
      release_out("bp");
      sb.push_back(model(1'b1, 32'd100, 32'd1, 1'b0));
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      check("bp_new_accepted", 32'(IN_READY), 32'd0);
      wait_out("bp_new");
      compare_pop("bp_new");
      release_out("bp_new");

      // Reset while RUN processes slice 2
      launch_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      sb.delete();
      check("midrst_in_ready", 32'(IN_READY), 32'd1);
      check("midrst_out_valid", 32'(OUT_VALID), 32'd0);
      check("midrst_result", RESULT, 32'd0);
      check("midrst_flags", {28'd0, COUT, ZERO, NEG, OVF}, 32'd0);
      full_op("after_rst", 1'b1, 32'd0, 32'd0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
